pwm_pair_monitor: RTL and testbench
===================================

Name: pwm_pair_monitor

Overview:
- Synthesisable on-chip monitor for NUM_CH complementary PWM motor-drive pairs (pwm1/pwm2 per channel).
- Generalises the bench-level PWM value check and NEMO-setup wait into a reusable hardware block.
- Per-window duty measurement, shoot-through detection, stuck-output detection, and a setup-done watchdog.
- Sits beside the motor-drive block; its outputs feed status registers or a debug UART response.

Parameters:
- NUM_CH, 2: number of PWM pairs monitored.
- WIN_W, 11: measurement window is 2^WIN_W cycles; duty fields are WIN_W+1 bits wide.
- STUCK_CYC, 4096: cycles without a pwm1 edge before stuck_err is set; must be ≥2.
- SETUP_TO, 500000: cycles allowed for setup_done to rise after reset; must be ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- pwm1  in  NUM_CH  high-side PWM per channel, same clock domain
- pwm2  in  NUM_CH  low-side PWM per channel
- setup_done  in  1  level from the sensor/inertial interface: setup complete
- clr_err  in  1  one-cycle pulse that clears the sticky shoot_err and stuck_err flags
- duty  out  NUM_CH*(WIN_W+1)  pwm1 high-cycle count of the last window; channel i occupies bits [i*(WIN_W+1) +: WIN_W+1]
- duty_vld  out  1  one-cycle pulse when duty updates
- shoot_err  out  NUM_CH  sticky: pwm1 and pwm2 were high in the same cycle
- stuck_err  out  NUM_CH  sticky: no pwm1 edge for STUCK_CYC cycles
- setup_ok  out  1  setup_done was seen before the timeout
- setup_to  out  1  setup timed out

Behaviour:
- Reset: rst is sampled on the rising edge of clk only. Every output and internal counter resets to 0, and the FSM goes to WAIT. Asserting rst mid-window discards the partial window with no duty_vld.
- Input stage: pwm1 and pwm2 are registered once into pwm1_q and pwm2_q. All checks use the _q values, so response latency is measured from the registered sample.
- Window counter: WIN_W bits, increments every cycle, wraps from 2^WIN_W-1 to 0. The first window starts on the first cycle after rst deasserts.
- Duty accumulation: hi_cnt[i] (WIN_W+1 bits) adds pwm1_q[i] each cycle.
- Terminal cycle (window count = 2^WIN_W-1):
  - duty[i] is loaded with hi_cnt[i] + pwm1_q[i], so the last cycle counts.
  - hi_cnt[i] is set to 0.
  - duty_vld pulses high in the following cycle, coincident with the new duty value.
  - duty range is 0 to 2^WIN_W; a constant-high input reads exactly 2^WIN_W.
- Shoot-through: pwm1_q[i] & pwm2_q[i] sets shoot_err[i] on the next edge. Both low (dead time) is legal.
- Stuck detection:
  - stk_cnt[i] resets to 0 on any pwm1_q[i] change versus its previous value; otherwise it increments and saturates at STUCK_CYC.
  - stuck_err[i] sets when stk_cnt[i] reaches STUCK_CYC-1 and no edge occurs that cycle.
  - A constant 0% or 100% drive is flagged by design.
- Sticky clear: clr_err clears all shoot_err and stuck_err bits and does not reset stk_cnt. A set condition and clr_err in the same cycle leave the flag set (set wins).
- Setup watchdog FSM, with a counter of ceil(log2(SETUP_TO)) bits:
  - WAIT: counter increments each cycle.
    - setup_done=1 → go to OK, setup_ok=1 next cycle.
    - Counter = SETUP_TO-1 and setup_done=0 → go to TIMEOUT, setup_to=1 next cycle.
    - setup_done on the terminal cycle → go to OK (setup wins).
  - OK and TIMEOUT are absorbing until rst. setup_done in TIMEOUT is ignored; a later setup_done drop in OK is ignored.
  - clr_err has no effect on the FSM.
  - setup_ok and setup_to are never both 1.
- Channels are fully independent; errors on one channel never affect another channel's duty or flags.

Test Plan:
- NUM_CH=2, WIN_W=4; ch0 pwm1 high 5 of every 16 cycles, aligned to the window, pwm2=~pwm1 with 1-cycle dead time → duty[0]=5 on each duty_vld, exactly 16 cycles apart; shoot_err=0.
- pwm1[1] held 1, pwm2[1] held 0 → duty[1]=16 on every window; stuck_err[1] set STUCK_CYC cycles after the last edge (+1 register cycle).
- Force pwm1[0]=pwm2[0]=1 for one cycle → shoot_err[0]=1 two edges later, stays 1; shoot_err[1]=0. Pulse clr_err while pwm1&pwm2 are still high → flag stays 1. Pulse clr_err after the overlap ends → flag is 0.
- SETUP_TO=100, setup_done rises at cycle 40 → setup_ok=1 at cycle 41, setup_to stays 0. Second run with no setup_done → setup_to=1 at cycle 100. Raising setup_done afterwards leaves setup_ok=0.
- setup_done rises on exactly the terminal count cycle → setup_ok=1, setup_to=0.
- Assert rst for one cycle mid-window with errors set → all outputs 0 next cycle, no duty_vld for the aborted window, and the next duty_vld arrives 2^WIN_W cycles after rst deasserts.

Source files
------------

// File: rtl/pwm_pair_monitor.sv
// rtl/pwm_pair_monitor.sv - duty, shoot-through, stuck-output and setup watchdog monitor for complementary PWM pairs
module pwm_pair_monitor #(
   parameter int NUM_CH    = 2,
   parameter int WIN_W     = 11,
   parameter int STUCK_CYC = 4096,
   parameter int SETUP_TO  = 500000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             pwm1,
   input  logic [NUM_CH-1:0]             pwm2,
   input  logic                          setup_done,
   input  logic                          clr_err,
   output logic [NUM_CH*(WIN_W+1)-1:0]   duty,
   output logic                          duty_vld,
   output logic [NUM_CH-1:0]             shoot_err,
   output logic [NUM_CH-1:0]             stuck_err,
   output logic                          setup_ok,
   output logic                          setup_to
);

   localparam int DW = WIN_W + 1;
   localparam int SW = $clog2(STUCK_CYC + 1);
   localparam int TW = $clog2(SETUP_TO);
   localparam logic [SW-1:0] STK_MAX  = SW'(STUCK_CYC);
   localparam logic [SW-1:0] STK_TRIP = SW'(STUCK_CYC - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(SETUP_TO - 1);

   typedef enum logic [1:0] {
      S_WAIT    = 2'd0,
      S_OK      = 2'd1,
      S_TIMEOUT = 2'd2
   } state_t;

   logic [NUM_CH-1:0] pwm1_q;
   logic [NUM_CH-1:0] pwm2_q;
   logic [NUM_CH-1:0] pwm1_prev;
   logic [NUM_CH-1:0] pwm1_edge;
   logic [NUM_CH-1:0] stuck_set;
   logic [WIN_W-1:0]  win_cnt;
   logic              win_last;
   logic [DW-1:0]     hi_cnt  [NUM_CH];
   logic [SW-1:0]     stk_cnt [NUM_CH];
   logic [TW-1:0]     to_cnt;
   state_t            state;
   state_t            state_nxt;

   assign win_last  = (win_cnt == '1);
   assign pwm1_edge = pwm1_q ^ pwm1_prev;

   always_comb begin
      stuck_set = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         stuck_set[i] = !pwm1_edge[i] && (stk_cnt[i] >= STK_TRIP);
      end
   end

   // The terminal cycle folds its own sample into duty so a constant-high input reads 2^WIN_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm1_q    <= '0;
         pwm2_q    <= '0;
         pwm1_prev <= '0;
         win_cnt   <= '0;
         duty      <= '0;
         duty_vld  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            hi_cnt[i]  <= '0;
            stk_cnt[i] <= '0;
         end
      end else begin
         pwm1_q    <= pwm1;
         pwm2_q    <= pwm2;
         pwm1_prev <= pwm1_q;
         win_cnt   <= win_cnt + WIN_W'(1);
         duty_vld  <= win_last;
         for (int i = 0; i < NUM_CH; i++) begin
            if (win_last) begin
               duty[i*DW +: DW] <= hi_cnt[i] + DW'(pwm1_q[i]);
               hi_cnt[i]        <= '0;
            end else begin
               hi_cnt[i] <= hi_cnt[i] + DW'(pwm1_q[i]);
            end
            if (pwm1_edge[i]) begin
               stk_cnt[i] <= '0;
            end else if (stk_cnt[i] != STK_MAX) begin
               stk_cnt[i] <= stk_cnt[i] + SW'(1);
            end
         end
      end
   end

   // Sticky flags: a set condition in the same cycle as clr_err wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         shoot_err <= '0;
         stuck_err <= '0;
      end else begin
         shoot_err <= (pwm1_q & pwm2_q) | (shoot_err & ~{NUM_CH{clr_err}});
         stuck_err <= stuck_set | (stuck_err & ~{NUM_CH{clr_err}});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_WAIT;
         to_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_WAIT) begin
            to_cnt <= to_cnt + TW'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT: begin
            if (setup_done) begin
               state_nxt = S_OK;
            end else if (to_cnt == TO_LAST) begin
               state_nxt = S_TIMEOUT;
            end
         end
         default: state_nxt = state;
      endcase
   end

   assign setup_ok = (state == S_OK);
   assign setup_to = (state == S_TIMEOUT);

endmodule

// File: tb/tb_pwm_pair_monitor.sv
// tb/tb_pwm_pair_monitor.sv - randomized self-checking bench for pwm_pair_monitor against a behavioural model
`timescale 1ns/1ps
module tb_pwm_pair_monitor;

   localparam int NUM_CH    = 2;
   localparam int WIN_W     = 4;
   localparam int STUCK_CYC = 40;
   localparam int SETUP_TO  = 100;
   localparam int DW        = WIN_W + 1;
   localparam int WIN       = 1 << WIN_W;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_CH-1:0]        pwm1;
   logic [NUM_CH-1:0]        pwm2;
   logic                     setup_done;
   logic                     clr_err;
   logic [NUM_CH*DW-1:0]     duty;
   logic                     duty_vld;
   logic [NUM_CH-1:0]        shoot_err;
   logic [NUM_CH-1:0]        stuck_err;
   logic                     setup_ok;
   logic                     setup_to;

   int n_chk = 0;
   int n_err = 0;

   // Model: m_cyc counts edges since reset; m_run is the length of the constant run
   // of pwm1 samples ending at the newest sample (reset seeds two zero samples).
   int m_cyc;
   int m_vld;
   int m_state;
   int m_q1    [NUM_CH];
   int m_q2    [NUM_CH];
   int m_run   [NUM_CH];
   int m_acc   [NUM_CH];
   int m_duty  [NUM_CH];
   int m_shoot [NUM_CH];
   int m_stuck [NUM_CH];
   int hold    [NUM_CH];
   int last_vld;
   int got;

   always #5 clk = ~clk;

   pwm_pair_monitor #(
      .NUM_CH    (NUM_CH),
      .WIN_W     (WIN_W),
      .STUCK_CYC (STUCK_CYC),
      .SETUP_TO  (SETUP_TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm1       (pwm1),
      .pwm2       (pwm2),
      .setup_done (setup_done),
      .clr_err    (clr_err),
      .duty       (duty),
      .duty_vld   (duty_vld),
      .shoot_err  (shoot_err),
      .stuck_err  (stuck_err),
      .setup_ok   (setup_ok),
      .setup_to   (setup_to)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, m_cyc);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_cyc   = 0;
         m_vld   = 0;
         m_state = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_q1[c]    = 0;
            m_q2[c]    = 0;
            m_run[c]   = 2;
            m_acc[c]   = 0;
            m_duty[c]  = 0;
            m_shoot[c] = 0;
            m_stuck[c] = 0;
         end
      end else begin
         m_cyc++;
         for (int c = 0; c < NUM_CH; c++) begin
            m_shoot[c] = ((m_q1[c] != 0 && m_q2[c] != 0) || (m_shoot[c] != 0 && !clr_err)) ? 1 : 0;
            m_stuck[c] = ((m_run[c] > STUCK_CYC) || (m_stuck[c] != 0 && !clr_err)) ? 1 : 0;
            m_acc[c]   = m_acc[c] + m_q1[c];
            m_run[c]   = (int'(pwm1[c]) == m_q1[c]) ? m_run[c] + 1 : 1;
            m_q1[c]    = int'(pwm1[c]);
            m_q2[c]    = int'(pwm2[c]);
         end
         m_vld = (m_cyc % WIN == 0) ? 1 : 0;
         if (m_vld != 0) begin
            for (int c = 0; c < NUM_CH; c++) begin
               m_duty[c] = m_acc[c];
               m_acc[c]  = 0;
            end
         end
         if (m_state == 0) begin
            if (setup_done) m_state = 1;
            else if (m_cyc == SETUP_TO) m_state = 2;
         end
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < NUM_CH; c++) begin
         chk($sformatf("duty%0d", c), 64'(duty[c*DW +: DW]), 64'(m_duty[c]));
         chk($sformatf("shoot_err%0d", c), 64'(shoot_err[c]), 64'(m_shoot[c]));
         chk($sformatf("stuck_err%0d", c), 64'(stuck_err[c]), 64'(m_stuck[c]));
      end
      chk("duty_vld", 64'(duty_vld), 64'(m_vld));
      chk("setup_ok", 64'(setup_ok), 64'(m_state == 1));
      chk("setup_to", 64'(setup_to), 64'(m_state == 2));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_step();
      check_all();
   endtask

   // ch0: high for samples 1..5 of each window, low side 7..15 (dead time either side); ch1 held high.
   task automatic drive_pattern();
      int k;
      k = m_cyc % WIN;
      pwm1[0] = (k < 5);
      pwm2[0] = (k >= 6 && k < 15);
      pwm1[1] = 1'b1;
      pwm2[1] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; pwm1 = '0; pwm2 = '0; setup_done = 1'b0; clr_err = 1'b0;
      step();
      step();
      chk("rst_duty", 64'(duty), 64'(0));
      chk("rst_flags", 64'({shoot_err, stuck_err, setup_ok, setup_to, duty_vld}), 64'(0));
      rst = 1'b0;

      last_vld = -1;
      for (int i = 0; i < 64; i++) begin
         drive_pattern();
         setup_done = (m_cyc >= 40);
         step();
         if (duty_vld) begin
            chk("duty0_is_5", 64'(duty[DW-1:0]), 64'(5));
            if (m_cyc > WIN) chk("duty1_full", 64'(duty[2*DW-1:DW]), 64'(WIN));
            if (last_vld >= 0) chk("vld_gap", 64'(m_cyc - last_vld), 64'(WIN));
            last_vld = m_cyc;
         end
         if (m_cyc == 40) chk("setup_ok_c40", 64'(setup_ok), 64'(0));
         if (m_cyc == 41) chk("setup_ok_c41", 64'(setup_ok), 64'(1));
         if (m_cyc == 41) chk("stuck1_c41", 64'(stuck_err[1]), 64'(0));
         if (m_cyc == 42) chk("stuck1_c42", 64'(stuck_err[1]), 64'(1));
      end
      chk("shoot_none", 64'(shoot_err), 64'(0));
      chk("setup_to_none", 64'(setup_to), 64'(0));

      pwm1[0] = 1'b1; pwm2[0] = 1'b1;
      step();
      pwm1[0] = 1'b0; pwm2[0] = 1'b0;
      chk("shoot0_edge1", 64'(shoot_err[0]), 64'(0));
      step();
      chk("shoot0_edge2", 64'(shoot_err[0]), 64'(1));
      chk("shoot1_clean", 64'(shoot_err[1]), 64'(0));
      step();
      step();
      chk("shoot0_sticky", 64'(shoot_err[0]), 64'(1));
      pwm1[0] = 1'b1; pwm2[0] = 1'b1;
      step();
      step();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("clr_set_wins", 64'(shoot_err[0]), 64'(1));
      pwm1[0] = 1'b0; pwm2[0] = 1'b0;
      step();
      step();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("clr_clears", 64'(shoot_err[0]), 64'(0));

      rst = 1'b1; setup_done = 1'b0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 110; i++) begin
         drive_pattern();
         setup_done = (m_cyc >= 105);
         step();
         if (m_cyc == SETUP_TO - 1) chk("to_before", 64'(setup_to), 64'(0));
         if (m_cyc == SETUP_TO)     chk("to_at_limit", 64'(setup_to), 64'(1));
      end
      chk("late_setup_ignored", 64'(setup_ok), 64'(0));
      chk("to_held", 64'(setup_to), 64'(1));

      rst = 1'b1; setup_done = 1'b0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 105; i++) begin
         drive_pattern();
         setup_done = (m_cyc == SETUP_TO - 1);
         step();
         if (m_cyc == SETUP_TO) chk("terminal_setup_ok", 64'(setup_ok), 64'(1));
         if (m_cyc == SETUP_TO) chk("terminal_setup_to", 64'(setup_to), 64'(0));
      end
      chk("setup_drop_ignored", 64'(setup_ok), 64'(1));

      pwm1[0] = 1'b1; pwm2[0] = 1'b1;
      step();
      step();
      for (int i = 0; i < WIN && (m_cyc % WIN) != 7; i++) begin
         drive_pattern();
         step();
      end
      chk("pre_rst_shoot", 64'(shoot_err[0]), 64'(1));
      chk("pre_rst_stuck", 64'(stuck_err[1]), 64'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_duty", 64'(duty), 64'(0));
      chk("midrst_flags", 64'({shoot_err, stuck_err, setup_ok, setup_to, duty_vld}), 64'(0));
      got = 0;
      for (int i = 1; i <= WIN + 4; i++) begin
         drive_pattern();
         step();
         if (duty_vld) begin
            chk("vld_after_rst", 64'(i), 64'(WIN));
            got = 1;
            break;
         end
      end
      if (got == 0) chk("vld_after_rst_timeout", 64'(0), 64'(1));

      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < NUM_CH; c++) hold[c] = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            int r;
            if (hold[c] == 0) begin
               pwm1[c] = 1'($urandom_range(0, 1));
               hold[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 60))
                                                     : int'($urandom_range(1, 8));
            end
            hold[c]--;
            r = int'($urandom_range(0, 19));
            pwm2[c] = (r == 0) ? 1'b1 : ((r < 4) ? 1'b0 : ~pwm1[c]);
         end
         clr_err    = ($urandom_range(0, 49) == 0);
         setup_done = ($urandom_range(0, 199) == 0);
         rst        = ($urandom_range(0, 499) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
